// File: rtl/s_mix_pipe.sv
// Two-stage valid/ready byte-mixing pipeline: each 32-bit lane {A0,A1,A2,A3} -> xt(A1^A2)^A0^A2^A3.
// Optional output chaining (XOR with the previous transferred byte) is built when S_MIX_CHAIN_EN is defined.
module s_mix_pipe #(
  parameter int unsigned LANES = 4,
  parameter logic [7:0]  POLY  = 8'h1B,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [32*LANES-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  input  logic                 chain_en,
  input  logic                 chain_load,
  input  logic [8*LANES-1:0]   chain_iv,
  output logic [CNT_W-1:0]     word_count
);

  function automatic logic [7:0] xt(input logic [7:0] v);
    xt = {v[6:0], 1'b0} ^ (v[7] ? POLY : 8'h00);
  endfunction

  logic                 s1_valid_q, s1_valid_d;
  logic [8*LANES-1:0]   s1_x_q, s1_x_d;
  logic [8*LANES-1:0]   s1_y_q, s1_y_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [8*LANES-1:0]   s2_m_q, s2_m_d;
  logic [CNT_W-1:0]     word_count_q, word_count_d;
  logic                 s1_advance, s2_advance, in_fire, out_fire;

  always_comb begin
    s2_advance = !s2_valid_q | out_ready;
    s1_advance = !s1_valid_q | s2_advance;
    in_fire    = in_valid & s1_advance;
    out_fire   = s2_valid_q & out_ready;

    s1_valid_d = s1_advance ? in_valid : s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    if (in_fire) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        s1_x_d[8*i +: 8] = in_data[32*i+16 +: 8] ^ in_data[32*i+8 +: 8];
        s1_y_d[8*i +: 8] = in_data[32*i+24 +: 8] ^ in_data[32*i+8 +: 8]
                         ^ in_data[32*i +: 8];
      end
    end

    s2_valid_d = s2_advance ? s1_valid_q : s2_valid_q;
    s2_m_d     = s2_m_q;
    if (s2_advance & s1_valid_q) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        s2_m_d[8*i +: 8] = xt(s1_x_q[8*i +: 8]) ^ s1_y_q[8*i +: 8];
      end
    end

    word_count_d = word_count_q + CNT_W'(out_fire);
  end

  // Data registers carry no reset; only valid flags, the counter and chain state do.
  always_ff @(posedge clk) begin
    s1_x_q <= s1_x_d;
    s1_y_q <= s1_y_d;
    s2_m_q <= s2_m_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      word_count_q <= word_count_d;
    end
  end

`ifdef S_MIX_CHAIN_EN
  logic [8*LANES-1:0] chain_q, chain_d;

  // A same-cycle load wins over the transfer update; the transferred byte still used the old value.
  always_comb begin
    out_data = chain_en ? (s2_m_q ^ chain_q) : s2_m_q;
    chain_d  = chain_q;
    if (chain_load)
      chain_d = chain_iv;
    else if (out_fire & chain_en)
      chain_d = out_data;
  end

  always_ff @(posedge clk) begin
    if (rst) chain_q <= '0;
    else     chain_q <= chain_d;
  end
`else
  logic unused_chain;
  assign unused_chain = ^{chain_en, chain_load, chain_iv};
  assign out_data     = s2_m_q;
`endif

  assign in_ready   = s1_advance;
  assign out_valid  = s2_valid_q;
  assign word_count = word_count_q;

endmodule

// File: doc/s_mix_pipe.md
S_MIX_PIPE -- requirements
Module: s_mix_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4: number of independent 32-bit-to-8-bit mixing lanes per beat.
REQ-002 SHALL have parameter POLY, default 8'h1B: reduction constant XORed after the left shift when the shifted-out bit is 1.
REQ-003 SHALL have parameter CNT_W, default 16: width of the beat counter.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1: in_data is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1: block accepts a beat this cycle.
REQ-008 SHALL have port in_data, input, 32*LANES: lane i occupies bits [32i+31:32i], with A0 as the top byte and A3 as the bottom byte.
REQ-009 SHALL have port out_valid, output, 1: out_data is valid this cycle.
REQ-010 SHALL have port out_ready, input, 1: sink accepts out_data this cycle.
REQ-011 SHALL have port out_data, output, 8*LANES: lane i occupies bits [8i+7:8i].
REQ-012 SHALL have port chain_en, input, 1: enables chained output mode (see Configuration).
REQ-013 SHALL have port chain_load, input, 1: loads chain_iv into the chain register.
REQ-014 SHALL have port chain_iv, input, 8*LANES: per-lane initial chain value.
REQ-015 SHALL have port word_count, output, CNT_W: number of output beats transferred, modulo 2^CNT_W.

Function
REQ-016 SHALL compute each lane as m = xt(A1^A2) ^ A0 ^ A2 ^ A3.
- xt(x) = {x[6:0],1'b0} ^ (x[7] ? POLY : 0).
REQ-017 SHALL be a two-stage valid/ready pipeline.
- Stage 1 registers x = A1^A2 and y = A0^A2^A3 per lane.
- Stage 2 registers xt(x)^y.
REQ-018 SHALL give latency 2 cycles from the in_valid&in_ready edge to out_valid when the sink never stalls, and SHALL sustain throughput of 1 beat/cycle.
REQ-019 SHALL drive in_ready = !s1_valid | s2_advance, where s2_advance = !s2_valid | out_ready.
- in_ready SHALL NOT depend combinationally on in_valid.
REQ-020 SHALL hold out_data and out_valid stable while out_valid & !out_ready.
REQ-021 SHALL neither drop nor duplicate beats.
- Bench check: beats out equals beats in, in order, under any out_ready pattern.
REQ-022 SHALL increment word_count by 1 on each out_valid&out_ready cycle, wrapping from 2^CNT_W-1 to 0.
REQ-023 SHALL treat each lane as fully independent; no bits cross lanes.

Reset
REQ-024 SHALL, when rst is high at a clock edge, clear s1_valid, s2_valid, word_count and all chain registers to 0.
- This forces out_valid=0 and word_count=0 in the following cycle.
REQ-025 SHALL drive in_ready=1 in the first cycle after reset is released.
REQ-026 SHALL discard in-flight beats when reset is asserted mid-stream; no output is produced for them.
REQ-027 SHALL give rst priority over every other input, including chain_load and any transfer.
REQ-028 SHALL hold data registers at don't-care during reset; only valid, count and chain state are reset.

Configuration
REQ-029 SHALL, with macro S_MIX_CHAIN_EN defined, produce lane output = stage-2 value ^ chain_reg[i] when chain_en=1, and the raw stage-2 value when chain_en=0.
- On each output transfer with chain_en=1, chain_reg[i] SHALL take the transferred out_data byte.
- chain_load SHALL set chain_reg to chain_iv at the next edge.
- If chain_load and a transfer fall in the same cycle, the transferred byte SHALL use the old chain_reg, and chain_reg SHALL take chain_iv.
- chain_en SHALL be sampled at the output stage, in the cycle of transfer.
REQ-030 SHALL, without S_MIX_CHAIN_EN, contain no chain registers; chain_en, chain_load and chain_iv SHALL be ignored, and out_data SHALL equal the stage-2 value.

Verification
REQ-031 SHALL cover: LANES=1, POLY=8'h1B, in_data=32'h01020304, out_ready=1 -> out_data=8'h04 exactly 2 cycles after acceptance, word_count=1.
REQ-032 SHALL cover: in_data=32'h00800000 -> 8'h1B with POLY=8'h1B; rebuild with POLY=8'h1D -> 8'h1D.
REQ-033 SHALL cover: LANES=4, 16 back-to-back beats, out_ready toggling 1010... -> all 16 results in order, none lost, in_ready low only while both stages are full and out_ready=0.
REQ-034 SHALL cover: S_MIX_CHAIN_EN defined, chain_load with chain_iv=8'hFF, then chain_en=1 and two beats of 32'h01020304 -> 8'hFB, then 8'hFF.
REQ-035 SHALL cover: CNT_W=4, 17 transfers -> word_count=1; rst asserted with both stages full -> out_valid=0 and word_count=0 the next cycle, and no stale beat emerges afterwards.
